// File: rtl/semi_auto_nav.sv
// semi_auto_nav: right-hand-wall maze navigation controller.
// Turns obstacle-detector bits into move/turn command levels.
//
// Ports:
//   sys_clk              in   system clock
//   rst                  in   synchronous active-low reset
//   enable               in   auto mode active; low forces IDLE
//   front_detector       in   1 = wall ahead
//   left_detector        in   1 = wall on left
//   right_detector       in   1 = wall on right
//   back_detector        in   1 = wall behind (status only)
//   move_forward_signal  out  forward command level
//   turn_left_signal     out  left-turn command level
//   turn_right_signal    out  right-turn command level
//   move_backward_signal out  reverse command, tied low
//   nav_state            out  current state encoding
module semi_auto_nav #(
  parameter int unsigned TURN_CYCLES   = 90_000_000,
  parameter int unsigned SETTLE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       front_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  input  logic       back_detector,
  output logic       move_forward_signal,
  output logic       turn_left_signal,
  output logic       turn_right_signal,
  output logic       move_backward_signal,
  output logic [2:0] nav_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECIDE = 3'd1,
    S_FWD    = 3'd2,
    S_TURN_L = 3'd3,
    S_TURN_R = 3'd4,
    S_TURN_B = 3'd5,
    S_EXIT   = 3'd6
  } state_e;

  // Terminal counter values: a state of duration N
  // leaves on the edge where cnt == N-1.
  localparam logic [CNT_W-1:0] TURN_LAST =
    CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BACK_LAST =
    CNT_W'(2 * TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed;

  // Rear detector is reported by the link but
  // plays no part in the wall-following rule.
  logic unused_back;
  assign unused_back = back_detector;

  always_comb begin
    state_d = state_q;
    timed   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (!right_detector) begin
          state_d = S_TURN_R;
        end else if (!front_detector) begin
          state_d = S_EXIT;
        end else if (!left_detector) begin
          state_d = S_TURN_L;
        end else begin
          state_d = S_TURN_B;
        end
      end
      S_FWD: begin
        if (front_detector || !left_detector ||
            !right_detector) begin
          state_d = S_DECIDE;
        end
      end
      S_TURN_L, S_TURN_R: begin
        timed = 1'b1;
        if (cnt_q == TURN_LAST) begin
          state_d = S_EXIT;
        end
      end
      S_TURN_B: begin
        timed = 1'b1;
        if (cnt_q == BACK_LAST) begin
          state_d = S_EXIT;
        end
      end
      S_EXIT: begin
        // A wall ahead pre-empts the settle timer;
        // side openings are deliberately ignored
        // until the car has cleared the junction.
        timed = 1'b1;
        if (front_detector) begin
          state_d = S_DECIDE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_FWD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!enable) begin
      state_d = S_IDLE;
    end
  end

  // Counter restarts on every state change so each
  // timed state measures its own dwell from zero.
  always_comb begin
    cnt_d = '0;
    if (timed && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign move_forward_signal =
    (state_q == S_FWD) || (state_q == S_EXIT);
  assign turn_right_signal =
    (state_q == S_TURN_R) || (state_q == S_TURN_B);
  assign turn_left_signal     = (state_q == S_TURN_L);
  assign move_backward_signal = 1'b0;
  assign nav_state            = state_q;

endmodule

// File: tb/tb_semi_auto_nav.sv
// tb_semi_auto_nav: directed vector table plus
// randomized run against a timestamp-based model.
module tb_semi_auto_nav;

  localparam int T = 4;
  localparam int S = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       f   = 1'b0;
  logic       l   = 1'b1;
  logic       r   = 1'b1;
  logic       b   = 1'b0;
  logic       fwd, tl, tr, bk;
  logic [2:0] ns;

  int checks = 0;
  int errors = 0;

  semi_auto_nav #(
    .TURN_CYCLES  (T),
    .SETTLE_CYCLES(S),
    .CNT_W        (32)
  ) dut (
    .sys_clk             (clk),
    .rst                 (rst),
    .enable              (en),
    .front_detector      (f),
    .left_detector       (l),
    .right_detector      (r),
    .back_detector       (b),
    .move_forward_signal (fwd),
    .turn_left_signal    (tl),
    .turn_right_signal   (tr),
    .move_backward_signal(bk),
    .nav_state           (ns)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic en;
    logic f;
    logic l;
    logic r;
    int   exp;
  } vec_t;

  vec_t vq[$];

  // Reference: state plus the edge number at which
  // it was entered; a timed state of duration N
  // leaves when N edges have elapsed since entry.
  int edge_no = 0;
  int m_state = 0;
  int m_entry = 0;

  function automatic void add(logic r_, logic e_,
                              logic f_, logic l_,
                              logic rr_, int exp,
                              int n);
    vec_t v;
    v.rst = r_; v.en = e_; v.f = f_;
    v.l = l_; v.r = rr_; v.exp = exp;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  function automatic void model_update();
    int nxt;
    int age;
    age = edge_no - m_entry;
    nxt = m_state;
    if (!rst || !en) begin
      nxt = 0;
    end else begin
      case (m_state)
        0: nxt = 1;
        1: nxt = !r ? 4 : !f ? 6 : !l ? 3 : 5;
        2: nxt = (f || !l || !r) ? 1 : 2;
        3, 4: nxt = (age == T) ? 6 : m_state;
        5: nxt = (age == 2 * T) ? 6 : 5;
        6: nxt = f ? 1 : (age == S) ? 2 : 6;
        default: nxt = 0;
      endcase
    end
    if (nxt != m_state || !rst) m_entry = edge_no;
    m_state = nxt;
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  task automatic chk_outs(string tag, int s);
    chk({tag, " nav_state"}, int'(ns), s);
    chk({tag, " fwd"}, int'(fwd),
        int'(s == 2 || s == 6));
    chk({tag, " right"}, int'(tr),
        int'(s == 4 || s == 5));
    chk({tag, " left"}, int'(tl), int'(s == 3));
    chk({tag, " back"}, int'(bk), 0);
  endtask

  task automatic step(logic r_, logic e_, logic f_,
                      logic l_, logic rr_);
    rst = r_; en = e_; f = f_; l = l_; r = rr_;
    b = 1'($urandom);
    @(posedge clk);
    edge_no++;
    model_update();
    #1;
  endtask

  initial begin
    // reset held with enable high
    add(0, 1, 0, 1, 1, 0, 3);
    // corridor: DECIDE, EXIT x6, FORWARD
    add(1, 1, 0, 1, 1, 1, 1);
    add(1, 1, 0, 1, 1, 6, S);
    add(1, 1, 0, 1, 1, 2, 3);
    // right junction, R held low through EXIT
    add(1, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 1, 0, 4, T);
    add(1, 1, 0, 1, 0, 6, S - 1);
    add(1, 1, 0, 1, 1, 6, 1);
    add(1, 1, 0, 1, 1, 2, 1);
    // dead end, EXIT cut short by front wall
    add(1, 1, 1, 1, 1, 1, 1);
    add(1, 1, 1, 1, 1, 5, 2 * T);
    add(1, 1, 1, 1, 1, 6, 1);
    add(1, 1, 1, 1, 1, 1, 1);
    // left only
    add(1, 1, 1, 0, 1, 3, T);
    add(1, 1, 1, 0, 1, 6, 1);
    add(1, 1, 1, 0, 1, 1, 1);
    // enable drop at cycle 2 of TURN_R
    add(1, 1, 0, 1, 0, 4, 2);
    add(1, 0, 0, 1, 0, 0, 2);
    // reset mid-EXIT, then a full EXIT again
    add(1, 1, 0, 1, 1, 1, 1);
    add(1, 1, 0, 1, 1, 6, 3);
    add(0, 1, 0, 1, 1, 0, 1);
    add(1, 1, 0, 1, 1, 1, 1);
    add(1, 1, 0, 1, 1, 6, S);
    add(1, 1, 0, 1, 1, 2, 1);
    // enable low on the TURN_L expiry edge
    add(1, 1, 1, 0, 1, 1, 1);
    add(1, 1, 1, 0, 1, 3, T);
    add(1, 0, 1, 0, 1, 0, 1);
    // front wall on the EXIT expiry edge
    add(1, 1, 0, 1, 1, 1, 1);
    add(1, 1, 0, 1, 1, 6, S);
    add(1, 1, 1, 1, 1, 1, 1);

    @(negedge clk);
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].f,
           vq[i].l, vq[i].r);
      chk_outs($sformatf("vec%0d", i), vq[i].exp);
    end

    for (int i = 0; i < 3000; i++) begin
      logic nf, nl, nr, ne, nrst;
      nf = f; nl = l; nr = r;
      if ($urandom_range(3) == 0) begin
        nf = ($urandom_range(3) == 0);
        nl = ($urandom_range(3) != 0);
        nr = ($urandom_range(3) != 0);
      end
      ne   = ($urandom_range(63) != 0);
      nrst = ($urandom_range(127) != 0);
      step(nrst, ne, nf, nl, nr);
      chk_outs($sformatf("rand%0d", i), m_state);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/semi_auto_nav.md
# semi_auto_nav

Maze-navigation controller for the simulated car. It sits downstream of the UART link and consumes the four obstacle-detector bits returned by the simulator. It sits upstream of the driving logic and produces the move/turn command levels that replace the manual buttons when auto mode is active. It uses a right-hand-wall rule: hold forward while boxed in by side walls, decide at every junction or dead end, execute a timed turn, then drive clear of the junction before looking again.

## Interface
- TURN_CYCLES, 90_000_000, cycles a single 90° turn command is held (0.9 s at 100 MHz); must be ≥ 1
- SETTLE_CYCLES, 50_000_000, cycles of forced forward drive after a junction decision; must be ≥ 1
- CNT_W, 32, width of the internal duration counter; must hold 2*TURN_CYCLES
- sys_clk  in  1  100 MHz system clock
- rst  in  1  reset, synchronous, active-low
- enable  in  1  auto mode active (power on and auto selected); low forces IDLE
- front_detector  in  1  1 = wall directly ahead
- left_detector  in  1  1 = wall on left
- right_detector  in  1  1 = wall on right
- back_detector  in  1  1 = wall behind (status only, not used in decisions)
- move_forward_signal  out  1  forward command level
- turn_left_signal  out  1  left-turn command level
- turn_right_signal  out  1  right-turn command level
- move_backward_signal  out  1  reverse command; always 0 in this revision
- nav_state  out  3  current state encoding, for LEDs and debug

## Operation
- States and encodings: IDLE=0, DECIDE=1, FORWARD=2, TURN_L=3, TURN_R=4, TURN_BACK=5, EXIT=6; encoding 7 is illegal and recovers to IDLE.
- Outputs are a Moore decode of the state register and are mutually exclusive.
  - move_forward_signal = 1 in FORWARD and EXIT.
  - turn_right_signal = 1 in TURN_R and TURN_BACK.
  - turn_left_signal = 1 in TURN_L.
  - All outputs are 0 in IDLE and DECIDE.
- Priority rule: enable = 0 → IDLE on the next edge from any state. This overrides every transition below.
- IDLE: enable = 1 → DECIDE.
- DECIDE lasts one cycle and samples the detectors. Priority is first-match:
  - right = 0 → TURN_R
  - else front = 0 → EXIT
  - else left = 0 → TURN_L
  - else → TURN_BACK
- FORWARD: front = 1 or left = 0 or right = 0 → DECIDE; otherwise stay.
- TURN_L / TURN_R: held for exactly TURN_CYCLES cycles, then → EXIT.
- TURN_BACK: held for exactly 2*TURN_CYCLES cycles, then → EXIT.
- EXIT:
  - front = 1 → DECIDE immediately, checked before the counter.
  - Otherwise, after SETTLE_CYCLES cycles → FORWARD.
  - Side openings are ignored in EXIT.
- Duration counter:
  - Clears to 0 on every state entry.
  - Increments by 1 each cycle in the timed states.
  - The exit condition is cnt == limit−1; the counter never wraps.
- Reset (rst = 0 at an edge): state = IDLE, cnt = 0, all outputs 0, nav_state = 0. Reset applied mid-turn aborts the turn with no residual pulse.

## Timing
- Single clock domain. Detector inputs are treated as synchronous to sys_clk.
- Latency from detector change to command change is one edge: a change present before edge k updates the state at edge k, and the outputs change after edge k.
- Enable rising → DECIDE after 1 edge → first command after 2 edges.
- Enable falling → outputs 0 after 1 edge.
- Timed states: a state entered at edge k leaves at edge k+N, where N is the state's duration.
- Simultaneous events:
  - enable = 0 wins over any counter expiry.
  - In EXIT, front = 1 wins over counter expiry.
- Detector glitches during TURN_* have no effect.

## Test plan
(All scenarios use TURN_CYCLES=4, SETTLE_CYCLES=6.)
- Reset/idle: hold rst = 0 for 3 cycles with enable = 1 → all outputs 0 and nav_state = 0. Release rst → nav_state = 1 for one cycle, then follows the detectors.
- Corridor: detectors F=0, L=1, R=1 with enable → DECIDE → EXIT: move_forward high for 6 cycles, then FORWARD (nav_state = 2) with move_forward held steadily.
- Right junction: in FORWARD, drop R to 0 → DECIDE for 1 cycle → turn_right high exactly 4 cycles → EXIT with move_forward high 6 cycles (R held 0 is ignored) → FORWARD.
- Dead end: in FORWARD, set F=1, L=1, R=1 → DECIDE → TURN_BACK with turn_right high exactly 8 cycles → EXIT. With F=1 still set, EXIT lasts 1 cycle → DECIDE again.
- Left only: F=1, L=0, R=1 → turn_left high exactly 4 cycles, turn_right stays 0, then EXIT.
- Aborts:
  - Drop enable at cycle 2 of TURN_R → all outputs 0 and nav_state = 0 on the next edge.
  - Separately, assert rst = 0 mid-EXIT → same result, and cnt restarts from 0 on re-entry.
